mem_sequencer: RTL

Controller that sequences the Chip-8 memory manager's `address_counter`, `write_enable` and `write_count` inputs for four kinds of access: opcode fetch, bulk register store (FX55), bulk register load (FX65) and sprite read (DXYN). Requesters use a level request / one-cycle done handshake. A fixed-priority arbiter grants the single shared memory port to one requester at a time. The block sits between the CPU/display logic and the memory manager.

---
 rtl/mem_sequencer_if.sv | 27 ++
 rtl/mem_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - request/grant and memory-manager control bundle for mem_sequencer
interface mem_sequencer_if;
   logic       store_req;
   logic       load_req;
   logic       sprite_req;
   logic       fetch_req;
   logic [3:0] len_m1;
   logic [3:0] grant;
   logic       busy;
   logic       done;
   logic       err;
   logic [5:0] mem_address_counter;
   logic       mem_write_enable;
   logic [3:0] mem_write_count;

   // Requester / observer side
   modport master (
      output store_req, load_req, sprite_req, fetch_req, len_m1,
      input  grant, busy, done, err, mem_address_counter, mem_write_enable, mem_write_count
   );

   // Sequencer side
   modport slave (
      input  store_req, load_req, sprite_req, fetch_req, len_m1,
      output grant, busy, done, err, mem_address_counter, mem_write_enable, mem_write_count
   );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - arbitrated sequencer for Chip-8 memory manager fetch/store/load/sprite accesses
module mem_sequencer (
   input  logic           clk,
   input  logic           reset_n,
   mem_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] n_q, n_d;
   logic [3:0] grant_q, grant_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [5:0] cnt_q, cnt_d;
   logic       we_q, we_d;
   logic [3:0] wc_q, wc_d;

   // Byte count of the pending request; 16 only arises from len_m1 = 15
   logic [4:0] len_n;
   logic       last_count;

   assign len_n      = {1'b0, bus.len_m1} + 5'd1;
   assign last_count = (cnt_q == {1'b0, n_q});

   // Next-state and registered-output values, defaults first
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      wc_d    = wc_q;

      case (state_q)
         S_IDLE: begin
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 6'd0;
            wc_d    = 4'd0;
            n_d     = len_n;
            if (bus.store_req) begin
               grant_d = 4'b1000;
               busy_d  = 1'b1;
               if (len_n[4]) begin
                  // 16-byte store cannot be expressed in write_count: reject without writing
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_WRITE;
                  wc_d    = len_n[3:0];
               end
            end else if (bus.load_req) begin
               grant_d = 4'b0100;
               busy_d  = 1'b1;
               state_d = S_READ;
            end else if (bus.sprite_req) begin
               grant_d = 4'b0010;
               busy_d  = 1'b1;
               state_d = S_READ;
            end else if (bus.fetch_req) begin
               grant_d = 4'b0001;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            if (cnt_q == 6'd1) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               cnt_d   = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         S_READ: begin
            if (last_count) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               cnt_d   = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         S_WRITE: begin
            if (last_count) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               cnt_d   = 6'd0;
               wc_d    = 4'd0;
            end else begin
               // Count 0 is skipped because the manager's write pipeline is stale there
               cnt_d = cnt_q + 6'd1;
               we_d  = 1'b1;
            end
         end

         S_DONE: begin
            // One IDLE cycle follows so a requester dropping at done is never re-granted
            state_d = S_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 6'd0;
            wc_d    = 4'd0;
         end

         default: begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 6'd0;
            wc_d    = 4'd0;
         end
      endcase
   end

   // State and output registers; reset clears write enable without waiting for a clock
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         n_q     <= 5'd0;
         grant_q <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 6'd0;
         we_q    <= 1'b0;
         wc_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         wc_q    <= wc_d;
      end
   end

   assign bus.grant               = grant_q;
   assign bus.busy                = busy_q;
   assign bus.done                = done_q;
   assign bus.err                 = err_q;
   assign bus.mem_address_counter = cnt_q;
   assign bus.mem_write_enable    = we_q;
   assign bus.mem_write_count     = wc_q;

endmodule
